// File: rtl/helios_stream_pkg.sv
// Shared definitions for the Helios input stream: header tag, packer states,
// and the round-to-word sizing helper used by the packer and the unpacker.
package helios_stream_pkg;

    localparam logic [7:0] HEADER_TAG = 8'h01;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } packer_state_t;

    function automatic int words_per_round(int bits);
        return (bits + 31) / 32;
    endfunction

endpackage

// File: rtl/syndrome_stream_packer.sv
// Serialises one round of syndrome bits at a time onto the decoder core's
// 32-bit valid/ready stream, prefixing each block of rounds with a header word.
//
// state  | meaning
// S_WAIT | idle, ready to capture the next round
// S_HDR  | presenting the block header word
// S_DATA | presenting the data words of the captured round
module syndrome_stream_packer
    import helios_stream_pkg::*;
#(
    parameter int GRID_WIDTH_X = 12,
    parameter int GRID_WIDTH_Z = 2,
    parameter int GRID_WIDTH_U = 10,
    parameter int NUM_CONTEXTS = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] round_data,
    input  logic                                 round_valid,
    output logic                                 round_ready,
    output logic [31:0]                          out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 block_done
);

    localparam int PU_COUNT_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int WPR                = words_per_round(PU_COUNT_PER_ROUND);
    localparam int BUF_W              = WPR * 32;
    localparam int U_BIT_WIDTH        = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
    localparam int IDX_W              = (WPR > 1) ? $clog2(WPR) : 1;

    packer_state_t          state;
    logic [BUF_W-1:0]       buffer;
    logic [IDX_W-1:0]       word_idx;
    logic [U_BIT_WIDTH-1:0] round_idx;
    logic [7:0]             ctx_id;
    logic [15:0]            block_seq;

    logic [BUF_W-1:0] round_ext;
    logic [31:0]      header;
    logic [31:0]      next_word;
    logic             last_word;
    logic             last_round;

    assign round_ext  = BUF_W'(round_data);
    assign header     = {HEADER_TAG, ctx_id, block_seq};
    assign next_word  = 32'(buffer >> (32 * (int'(word_idx) + 1)));
    assign last_word  = (word_idx == IDX_W'(WPR - 1));
    assign last_round = (round_idx == U_BIT_WIDTH'(GRID_WIDTH_U - 1));

    assign round_ready = (state == S_WAIT);
    assign busy        = (round_idx != '0) || (state != S_WAIT);

    // out_data is loaded one step ahead so the word is registered when valid rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_WAIT;
            buffer     <= '0;
            word_idx   <= '0;
            round_idx  <= '0;
            ctx_id     <= 8'd0;
            block_seq  <= 16'd0;
            out_data   <= 32'd0;
            out_valid  <= 1'b0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (round_valid) begin
                        buffer    <= round_ext;
                        word_idx  <= '0;
                        out_valid <= 1'b1;
                        if (round_idx == '0) begin
                            state    <= S_HDR;
                            out_data <= header;
                        end else begin
                            state    <= S_DATA;
                            out_data <= round_ext[31:0];
                        end
                    end
                end
                S_HDR: begin
                    if (out_ready) begin
                        state    <= S_DATA;
                        out_data <= buffer[31:0];
                    end
                end
                S_DATA: begin
                    if (out_ready) begin
                        if (!last_word) begin
                            word_idx <= word_idx + 1'b1;
                            out_data <= next_word;
                        end else begin
                            state     <= S_WAIT;
                            out_valid <= 1'b0;
                            out_data  <= 32'd0;
                            if (last_round) begin
                                round_idx  <= '0;
                                ctx_id     <= (ctx_id == 8'(NUM_CONTEXTS - 1)) ? 8'd0 : ctx_id + 8'd1;
                                block_seq  <= block_seq + 16'd1;
                                block_done <= 1'b1;
                            end else begin
                                round_idx <= round_idx + 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_syndrome_stream_packer.sv
// Bench for syndrome_stream_packer: directed table, header rotation, stalls,
// mid-block reset, held round_valid and a two-word-per-round instance.
module tb_syndrome_stream_packer;

    localparam int U  = 10;
    localparam int NC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [23:0] round_data;
    logic        round_valid;
    logic        round_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        block_done;

    logic        d2_reset;
    logic [39:0] d2_round_data;
    logic        d2_round_valid;
    logic        d2_round_ready;
    logic [31:0] d2_out_data;
    logic        d2_out_valid;
    logic        d2_out_ready;
    logic        d2_busy;
    logic        d2_block_done;

    syndrome_stream_packer dut (
        .clk(clk), .reset(reset),
        .round_data(round_data), .round_valid(round_valid), .round_ready(round_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .block_done(block_done)
    );

    syndrome_stream_packer #(.GRID_WIDTH_X(20), .GRID_WIDTH_Z(2)) dut2 (
        .clk(clk), .reset(d2_reset),
        .round_data(d2_round_data), .round_valid(d2_round_valid), .round_ready(d2_round_ready),
        .out_data(d2_out_data), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .busy(d2_busy), .block_done(d2_block_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: expected word stream built from block/round rules
    logic [31:0] exp_q[$];
    bit          last_q[$];
    int          m_round   = 0;
    logic [7:0]  m_ctx     = 8'd0;
    logic [15:0] m_seq     = 16'd0;
    bit          busy_exp  = 1'b0;
    bit          last_cap  = 1'b0;
    int          caps      = 0;
    int          dones     = 0;

    task automatic model_capture(logic [23:0] d);
        if (m_round == 0) begin
            exp_q.push_back({8'h01, m_ctx, m_seq});
            last_q.push_back(1'b0);
        end
        exp_q.push_back({8'h00, d});
        last_q.push_back(m_round == U - 1);
        m_round++;
        if (m_round == U) begin
            m_round = 0;
            m_ctx   = 8'((int'(m_ctx) + 1) % NC);
            m_seq   = m_seq + 16'd1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_q.delete();
        m_round  = 0;
        m_ctx    = 8'd0;
        m_seq    = 16'd0;
        busy_exp = 1'b0;
    endtask

    task automatic tick();
        logic        hs_in;
        logic        hs_out;
        logic        stall;
        logic        exp_last;
        logic [31:0] held;
        hs_in    = round_valid && round_ready;
        hs_out   = out_valid && out_ready;
        stall    = out_valid && !out_ready;
        held     = out_data;
        exp_last = 1'b0;
        if (hs_in) model_capture(round_data);
        if (hs_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %h expected none", out_data);
            end else begin
                check("out_word", out_data, exp_q.pop_front());
                exp_last = last_q.pop_front();
            end
        end
        last_cap = hs_in;
        @(posedge clk);
        #1;
        if (hs_in) begin
            caps++;
            busy_exp = 1'b1;
        end
        if (exp_last) busy_exp = 1'b0;
        if (stall) begin
            check1("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, held);
        end
        check1("block_done", block_done, exp_last);
        check1("busy", busy, busy_exp);
        check1("ready_vs_valid", round_ready, !out_valid);
        if (block_done) dones++;
    endtask

    task automatic send_round(logic [23:0] d, bit chk_hdr, logic [31:0] hdr);
        int n = 0;
        round_data  = d;
        round_valid = 1'b1;
        while (!round_ready && n < 100) begin
            tick();
            n++;
        end
        if (!round_ready) begin
            fail_now("wait_round_ready");
            round_valid = 1'b0;
            return;
        end
        tick();
        round_valid = 1'b0;
        if (chk_hdr) begin
            check1("hdr_valid", out_valid, 1'b1);
            check("header", out_data, hdr);
        end
        n = 0;
        while (out_valid && n < 200) begin
            tick();
            n++;
        end
        if (out_valid) fail_now("wait_round_emitted");
    endtask

    typedef struct {
        logic [23:0] rdata;
        bit          has_hdr;
        logic [31:0] hdr;
        logic [31:0] word;
        bit          last;
    } vec_t;

    vec_t        tbl[U];
    logic [31:0] blk_hdr[2] = '{32'h01010001, 32'h01000002};

    initial begin
        int caps0;
        int dones0;
        int n;

        reset          = 1'b1;
        round_data     = 24'd0;
        round_valid    = 1'b0;
        out_ready      = 1'b0;
        d2_reset       = 1'b1;
        d2_round_data  = 40'd0;
        d2_round_valid = 1'b0;
        d2_out_ready   = 1'b0;

        for (int i = 0; i < U; i++) begin
            tbl[i].rdata   = 24'(i + 1);
            tbl[i].has_hdr = (i == 0);
            tbl[i].hdr     = 32'h01000000;
            tbl[i].word    = 32'(i + 1);
            tbl[i].last    = (i == U - 1);
        end

        repeat (2) @(posedge clk);
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check1("rst_block_done", block_done, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_round_ready", round_ready, 1'b1);
        reset = 1'b0;

        // Block 1: cycle-exact directed vectors
        out_ready = 1'b1;
        for (int i = 0; i < U; i++) begin
            round_data  = tbl[i].rdata;
            round_valid = 1'b1;
            check1("tbl_ready", round_ready, 1'b1);
            tick();
            round_valid = 1'b0;
            if (tbl[i].has_hdr) begin
                check1("tbl_hdr_valid", out_valid, 1'b1);
                check("tbl_hdr", out_data, tbl[i].hdr);
                tick();
            end
            check1("tbl_word_valid", out_valid, 1'b1);
            check("tbl_word", out_data, tbl[i].word);
            check1("tbl_busy_mid", busy, 1'b1);
            tick();
            check1("tbl_valid_low", out_valid, 1'b0);
            check1("tbl_ready_back", round_ready, 1'b1);
            check1("tbl_done", block_done, tbl[i].last);
            check1("tbl_busy_after", busy, !tbl[i].last);
        end

        // Blocks 2 and 3: context rotation and sequence increment
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < U; r++)
                send_round(24'($urandom), r == 0, blk_hdr[b]);

        // Block 4: round_valid held high throughout
        caps0       = caps;
        dones0      = dones;
        round_valid = 1'b1;
        round_data  = 24'($urandom);
        for (int i = 0; i < 2 * U + 1; i++) begin
            tick();
            if (i == 0) check("held_header", out_data, 32'h01010003);
            if (last_cap) round_data = 24'($urandom);
        end
        round_valid = 1'b0;
        check("held_captures", 32'(caps - caps0), 32'd10);
        check("held_dones", 32'(dones - dones0), 32'd1);

        // Block 5: reset after round 4 while a data word is stalled
        for (int r = 0; r < 4; r++)
            send_round(24'($urandom), r == 0, 32'h01000004);
        round_data  = 24'h0BEEF5;
        round_valid = 1'b1;
        out_ready   = 1'b0;
        tick();
        round_valid = 1'b0;
        check1("pre_reset_valid", out_valid, 1'b1);
        tick();
        #3;
        reset = 1'b1;
        #1;
        check1("async_rst_valid", out_valid, 1'b0);
        check1("async_rst_ready", round_ready, 1'b1);
        check1("async_rst_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        send_round(24'h5A5A5A, 1'b1, 32'h01000000);

        // Random traffic with a stalling sink against the reference model
        for (int cyc = 0; cyc < 800; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!round_valid || last_cap) begin
                round_valid = ($urandom_range(0, 2) != 0);
                round_data  = 24'($urandom);
            end
            tick();
        end
        round_valid = 1'b0;
        out_ready   = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);

        // Two words per round
        d2_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d2_reset = 1'b0;
        check1("d2_ready", d2_round_ready, 1'b1);
        d2_round_data  = 40'hAB_CDEF0123;
        d2_round_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_round_valid = 1'b0;
        check("d2_header", d2_out_data, 32'h01000000);
        @(posedge clk);
        #1;
        check("d2_word0", d2_out_data, 32'hCDEF0123);
        check1("d2_word0_valid", d2_out_valid, 1'b1);
        @(posedge clk);
        #1;
        check("d2_word1", d2_out_data, 32'h000000AB);
        check1("d2_word1_valid", d2_out_valid, 1'b1);
        @(posedge clk);
        #1;
        check1("d2_idle_valid", d2_out_valid, 1'b0);
        check1("d2_idle_ready", d2_round_ready, 1'b1);
        check1("d2_idle_busy", d2_busy, 1'b1);
        d2_round_data  = 40'h12_3456789A;
        d2_round_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_round_valid = 1'b0;
        check("d2_r1_word0", d2_out_data, 32'h3456789A);
        @(posedge clk);
        #1;
        check("d2_r1_word1", d2_out_data, 32'h00000012);
        @(posedge clk);
        #1;
        check1("d2_r1_done_valid", d2_out_valid, 1'b0);
        check1("d2_no_block_done", d2_block_done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
